// File: rtl/tb_mem_rsp_model_if.sv
// Request/response bundle between a table-walker memory requester and tb_mem_rsp_model.
interface tb_mem_rsp_model_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MCN_W  = 58,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned LAT_W  = 6
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [IDX_W-1:0]  req_idx_i;
    logic [MCN_W-1:0]  req_mcn_i;
    logic [LAT_W-1:0]  req_lat_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [IDX_W-1:0]  res_idx_o;
    logic [DATA_W-1:0] res_data_o;

    modport master (
        output req_valid_i, req_idx_i, req_mcn_i, req_lat_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_idx_o, res_data_o
    );

    modport slave (
        input  req_valid_i, req_idx_i, req_mcn_i, req_lat_i, res_ready_i,
        output req_ready_o, res_valid_o, res_idx_o, res_data_o
    );
endinterface

// File: rtl/tb_mem_rsp_model.sv
// Memory responder: DEPTH outstanding line reads, per-request latency, in-order or out-of-order return.
// Optional latency jitter from a 16-bit LFSR when TB_MEM_JITTER_EN is defined.
module tb_mem_rsp_model #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MCN_W  = 58,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LAT_W  = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    tb_mem_rsp_model_if.slave      mem,
    input  logic                   cfg_ooo_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int unsigned SLOT_W = $clog2(DEPTH);
    localparam int unsigned SEQ_W  = SLOT_W + 1;
    localparam int unsigned LANES  = DATA_W / 64;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IDX_W-1:0] idx_q      [DEPTH];
    logic [IDX_W-1:0] idx_d      [DEPTH];
    logic [MCN_W-1:0] mcn_q      [DEPTH];
    logic [MCN_W-1:0] mcn_d      [DEPTH];
    logic [LAT_W-1:0] slot_cnt_q [DEPTH];
    logic [LAT_W-1:0] slot_cnt_d [DEPTH];
    logic [SEQ_W-1:0] seq_q      [DEPTH];
    logic [SEQ_W-1:0] seq_d      [DEPTH];

    logic [SEQ_W-1:0]  alloc_seq_q, alloc_seq_d;
    logic [SEQ_W-1:0]  retire_seq_q, retire_seq_d;
    logic [SEQ_W-1:0]  occ_q, occ_d;
    logic              lock_q, lock_d;
    logic [SLOT_W-1:0] lock_slot_q, lock_slot_d;
    logic              ooo_q, ooo_d;

    logic              req_ready;
    logic              accept;
    logic              retire;
    logic              free_found;
    logic [SLOT_W-1:0] free_slot;
    logic              sel_found;
    logic [SLOT_W-1:0] sel_slot;
    logic [DEPTH-1:0]  elig;
    logic [LAT_W-1:0]  lat_eff;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_idx;

    assign req_ready = ~(&vld_q);
    assign accept    = mem.req_valid_i & req_ready;
    assign retire    = sel_found & mem.res_ready_i;

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!vld_q[i] && !free_found) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            elig[i] = vld_q[i] && (slot_cnt_q[i] == '0);
        end
    end

    // A presented response stays locked to its slot until accepted; otherwise
    // in-order mode only considers the slot holding the oldest sequence number.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        if (lock_q) begin
            sel_found = 1'b1;
            sel_slot  = lock_slot_q;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!sel_found && elig[i] && (ooo_q || (seq_q[i] == retire_seq_q))) begin
                    sel_found = 1'b1;
                    sel_slot  = SLOT_W'(i);
                end
            end
        end
    end

    always_comb begin
        res_data = '0;
        res_idx  = '0;
        if (sel_found) begin
            res_idx = idx_q[sel_slot];
            for (int unsigned k = 0; k < LANES; k++) begin
                res_data[k*64 +: 64] = (64'(mcn_q[sel_slot]) << 3) + 64'(k);
            end
        end
    end

`ifdef TB_MEM_JITTER_EN
    logic [15:0]    lfsr_q, lfsr_d;
    logic [LAT_W:0] lat_sum;

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        lat_sum = {1'b0, mem.req_lat_i} + (LAT_W+1)'(lfsr_q[2:0]);
        lat_eff = lat_sum[LAT_W] ? '1 : lat_sum[LAT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        lat_eff = mem.req_lat_i;
    end
`endif

    always_comb begin
        vld_d        = vld_q;
        idx_d        = idx_q;
        mcn_d        = mcn_q;
        slot_cnt_d   = slot_cnt_q;
        seq_d        = seq_q;
        alloc_seq_d  = alloc_seq_q + SEQ_W'(accept);
        retire_seq_d = retire_seq_q + SEQ_W'(retire);
        occ_d        = occ_q;
        lock_d       = lock_q;
        lock_slot_d  = lock_slot_q;
        ooo_d        = (vld_q == '0) ? cfg_ooo_i : ooo_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_cnt_q[i] != '0) begin
                slot_cnt_d[i] = slot_cnt_q[i] - LAT_W'(1);
            end
        end

        if (retire) begin
            vld_d[sel_slot] = 1'b0;
            lock_d          = 1'b0;
        end else if (sel_found) begin
            lock_d      = 1'b1;
            lock_slot_d = sel_slot;
        end

        if (accept) begin
            vld_d[free_slot]      = 1'b1;
            idx_d[free_slot]      = mem.req_idx_i;
            mcn_d[free_slot]      = mem.req_mcn_i;
            slot_cnt_d[free_slot] = lat_eff;
            seq_d[free_slot]      = alloc_seq_q;
        end

        case ({accept, retire})
            2'b10:   occ_d = occ_q + SEQ_W'(1);
            2'b01:   occ_d = occ_q - SEQ_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q        <= '0;
            alloc_seq_q  <= '0;
            retire_seq_q <= '0;
            occ_q        <= '0;
            lock_q       <= 1'b0;
            lock_slot_q  <= '0;
            ooo_q        <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_q[i]      <= '0;
                mcn_q[i]      <= '0;
                slot_cnt_q[i] <= '0;
                seq_q[i]      <= '0;
            end
        end else begin
            vld_q        <= vld_d;
            idx_q        <= idx_d;
            mcn_q        <= mcn_d;
            slot_cnt_q   <= slot_cnt_d;
            seq_q        <= seq_d;
            alloc_seq_q  <= alloc_seq_d;
            retire_seq_q <= retire_seq_d;
            occ_q        <= occ_d;
            lock_q       <= lock_d;
            lock_slot_q  <= lock_slot_d;
            ooo_q        <= ooo_d;
        end
    end

    assign mem.req_ready_o = req_ready;
    assign mem.res_valid_o = sel_found;
    assign mem.res_idx_o   = res_idx;
    assign mem.res_data_o  = res_data;
    assign busy_o          = |vld_q;
    assign cnt_o           = occ_q;

    a_req_hold: assert property (@(posedge clock) disable iff (!reset)
        mem.req_valid_i && !mem.req_ready_o |=> mem.req_valid_i);

    a_res_stable: assert property (@(posedge clock) disable iff (!reset)
        mem.res_valid_o && !mem.res_ready_i |=>
            mem.res_valid_o && $stable(mem.res_idx_o) && $stable(mem.res_data_o));
endmodule

// File: doc/tb_mem_rsp_model.md
Name: tb_mem_rsp_model

Overview:
- Parametrised, synthesizable memory responder for the table-walker memory port, driven from the memory interface in the fs bench.
- Accepts up to DEPTH outstanding requests (idx, mcn) with a per-request latency and returns 512-bit line data derived deterministically from mcn.
- Return order is in-order or out-of-order, selected at run time.

Parameters:
IDX_W, 4, width of request/response tag (ttw index)
MCN_W, 58, width of memory cache-line number
DATA_W, 512, response data width; multiple of 64
DEPTH, 8, outstanding slots; power of two, >=2
LAT_W, 6, width of per-request latency

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  slot available
req_idx_i  in  IDX_W  request tag
req_mcn_i  in  MCN_W  requested line number
req_lat_i  in  LAT_W  extra latency cycles for this request
res_valid_o  out  1  response valid
res_ready_i  in  1  response accepted
res_idx_o  out  IDX_W  tag of returned request
res_data_o  out  DATA_W  line data
cfg_ooo_i  in  1  1 = out-of-order return; sampled only while busy_o=0
busy_o  out  1  any slot occupied
cnt_o  out  $clog2(DEPTH)+1  occupied slot count

Behaviour:
- Reset (reset=0, async): all slots free; alloc/retire sequence counters = 0; response lock cleared. Outputs: req_ready_o=1 after reset deasserts, res_valid_o=0, res_idx_o=0, res_data_o=0, busy_o=0, cnt_o=0. Outstanding requests are discarded and never answered.
- Slot state: vld, idx, mcn, cnt[LAT_W], seq[$clog2(DEPTH)+1].
- Accept when req_valid_i & req_ready_o. Target is the lowest-index free slot. Load cnt=req_lat_i and seq=alloc_seq; alloc_seq++ (wraps naturally).
- req_ready_o = !(all slots vld), from registered state. A slot freed this cycle is not reusable until the next cycle.
- cnt decrements each cycle while >0. A slot is eligible when vld & cnt==0.
- Latency: accept at cycle T gives earliest res_valid_o at T+1+req_lat_i.
- Selection:
  - cfg_ooo_i=0: only the slot with seq==retire_seq is eligible.
  - cfg_ooo_i=1: lowest-index eligible slot.
- Lock: once res_valid_o=1, the selected slot is locked. res_idx_o/res_data_o stay stable until res_ready_i=1, even if a lower-index slot becomes eligible.
- On res_valid_o & res_ready_i: slot freed, lock released, retire_seq++. The next response is earliest the following cycle, giving a max 1 response per cycle with combinational re-select.
- Data: lane k (64-bit, k=0..DATA_W/64-1) = ({zero-extended mcn} << 3) + k.
- cnt_o updates on accept/retire. Simultaneous accept+retire leaves cnt_o unchanged.
- Full: DEPTH outstanding gives req_ready_o=0; req_valid_i may stay high without effect.
- Empty: res_valid_o=0, busy_o=0.
- cfg_ooo_i changed while busy_o=1 is ignored until idle.
- Assertions: req_valid_i must not drop before ready. res_* must be stable while valid & !ready.

Optional Feature:
TB_MEM_JITTER_EN
- Defined: a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset), advanced on every accept, adds lfsr[2:0] (0..7) to req_lat_i at allocation, saturating at 2^LAT_W-1.
- Undefined: latency is exactly req_lat_i; no LFSR logic.

Test Plan:
- Single request idx=3, mcn=0x10, lat=2 at cycle 10 → res_valid_o at cycle 13; res_idx_o=3; lane0=0x80, lane7=0x87.
- DEPTH=8 back-to-back, lat=20, res_ready_i=1 → req_ready_o=0 after 8th accept, 9th stalled. req_ready_o=1 the cycle after the first response; cnt_o peaks at 8.
- cfg_ooo_i=1: idx A lat=10, then idx B lat=0 → B returned before A.
- cfg_ooo_i=0 with the same stimulus → A first, then B the next cycle.
- Backpressure: res_ready_i=0 for 5 cycles with response pending, and a lower-index slot becomes eligible meanwhile → res_idx_o/res_data_o unchanged until the handshake.
- reset asserted with 4 outstanding → immediately res_valid_o=0, cnt_o=0. After release, no stale responses; new request idx=1, lat=0 returns after 1 cycle.
